perf_counter_reader: RTL and testbench

//  AXI4-Lite read-only master that snapshots the performance-counter bank.
//  On a start pulse it reads NUM_WORDS consecutive 32-bit words from BASE_ADDR into a local buffer.
//  It performs one read at a time and exposes the captured words on a random-access read port.

---
 rtl/perf_counter_reader.sv | 192 +++++++++++++++++++
 tb/tb_perf_counter_reader.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/perf_counter_reader.sv
// perf_counter_reader
//   AXI4-Lite read-only master that snapshots a performance-counter bank.
//   A start pulse reads NUM_WORDS consecutive 32-bit words from BASE_ADDR,
//   one transaction at a time, into a local buffer. The buffer is exposed on
//   a combinational random-access port (rd_idx -> rd_data).
//
//   Ports
//     clk, rst           clock, synchronous active-high reset
//     start              1-cycle snapshot request (dropped while busy)
//     busy, done, err    status: busy AR/R/DONE, 1-cycle done, sticky err
//     rd_idx, rd_data    buffer read port (0 for rd_idx >= NUM_WORDS)
//     m_axi_ar*, m_axi_r*  AXI4-Lite read channels
//     m_axi_aw*, m_axi_w*, m_axi_b*  write channels, tied off
//
//   Optional feature: define PERF_READER_TIMEOUT_EN to add an R-channel
//   watchdog. After TIMEOUT_CYCLES cycles without rvalid the current word is
//   filled with 32'hDEADBEEF, err is set and the snapshot ends early.
module perf_counter_reader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          NUM_WORDS      = 32,
    parameter int          TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic [4:0]  rd_idx,
    output logic [31:0] rd_data,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic        m_axi_awvalid,
    output logic        m_axi_wvalid,
    output logic        m_axi_bready,
    output logic [31:0] m_axi_awaddr,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb
);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_DONE} state_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_WORDS - 1);

    state_t              state_q, state_d;
    logic [4:0]          idx_q, idx_d;
    logic                err_q, err_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic [31:0]         araddr_q, araddr_d;
    // Always 32 entries; entries at or above NUM_WORDS are never written and
    // stay zero, so the read port needs no out-of-range indexing.
    logic [31:0][31:0]   buf_q, buf_d;
    logic [4:0]          idx_nxt;
`ifdef PERF_READER_TIMEOUT_EN
    logic [15:0]         wd_q, wd_d;
`endif

    assign idx_nxt = idx_q + 5'd1;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        err_d     = err_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
        araddr_d  = araddr_q;
        buf_d     = buf_q;
`ifdef PERF_READER_TIMEOUT_EN
        wd_d      = wd_q;
`endif
        // Outputs are registered: each branch sets the values the next state
        // will present, so arvalid/rready/busy/done line up with state_q.
        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d   = S_AR;
                    idx_d     = 5'd0;
                    err_d     = 1'b0;
                    busy_d    = 1'b1;
                    arvalid_d = 1'b1;
                    araddr_d  = BASE_ADDR;
                end
            end
            S_AR: begin
                arvalid_d = 1'b1;
                if (m_axi_arready) begin
                    state_d   = S_R;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
`ifdef PERF_READER_TIMEOUT_EN
                    wd_d      = 16'd0;
`endif
                end
            end
            S_R: begin
                rready_d = 1'b1;
                if (m_axi_rvalid) begin
                    // Data is kept even on an error response.
                    buf_d[idx_q] = m_axi_rdata;
                    if (m_axi_rresp != 2'b00) err_d = 1'b1;
                    rready_d = 1'b0;
                    if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = S_AR;
                        idx_d     = idx_nxt;
                        arvalid_d = 1'b1;
                        araddr_d  = BASE_ADDR + {25'd0, idx_nxt, 2'b00};
                    end
                end
`ifdef PERF_READER_TIMEOUT_EN
                else if (wd_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    // This is the TIMEOUT_CYCLES-th empty cycle: give up.
                    buf_d[idx_q] = 32'hDEAD_BEEF;
                    err_d        = 1'b1;
                    rready_d     = 1'b0;
                    state_d      = S_DONE;
                    done_d       = 1'b1;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= 5'd0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            araddr_q  <= 32'd0;
            buf_q     <= '0;
`ifdef PERF_READER_TIMEOUT_EN
            wd_q      <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            araddr_q  <= araddr_d;
            buf_q     <= buf_d;
`ifdef PERF_READER_TIMEOUT_EN
            wd_q      <= wd_d;
`endif
        end
    end

    assign rd_data = ({1'b0, rd_idx} < 6'(NUM_WORDS)) ? buf_q[rd_idx] : 32'd0;

    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;
    assign m_axi_awvalid = 1'b0;
    assign m_axi_wvalid  = 1'b0;
    assign m_axi_bready  = 1'b1;
    assign m_axi_awaddr  = 32'd0;
    assign m_axi_wdata   = 32'd0;
    assign m_axi_wstrb   = 4'd0;

endmodule

// File: tb/tb_perf_counter_reader.sv
module tb_perf_counter_reader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: 32 words at address 0
    logic        rst, start, busy, done, err;
    logic [4:0]  rd_idx;
    logic [31:0] rd_data, araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready, awvalid, wvalid, bready;
    logic [1:0]  rresp;
    logic [3:0]  wstrb;

    perf_counter_reader #(.BASE_ADDR(32'h0), .NUM_WORDS(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .rd_idx(rd_idx), .rd_data(rd_data),
        .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
        .m_axi_awvalid(awvalid), .m_axi_wvalid(wvalid), .m_axi_bready(bready),
        .m_axi_awaddr(awaddr), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb));

    // Second DUT: 4 words near the top of the address space (wrap + short buffer)
    logic        start2, busy2, done2, err2;
    logic [4:0]  rd_idx2;
    logic [31:0] rd_data2, araddr2, rdata2, awaddr2, wdata2;
    logic        arvalid2, arready2, rvalid2, rready2, awvalid2, wvalid2, bready2;
    logic [1:0]  rresp2;
    logic [3:0]  wstrb2;

    perf_counter_reader #(.BASE_ADDR(32'hFFFF_FFF8), .NUM_WORDS(4), .TIMEOUT_CYCLES(16)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .err(err2),
        .rd_idx(rd_idx2), .rd_data(rd_data2),
        .m_axi_araddr(araddr2), .m_axi_arvalid(arvalid2), .m_axi_arready(arready2),
        .m_axi_rdata(rdata2), .m_axi_rresp(rresp2), .m_axi_rvalid(rvalid2), .m_axi_rready(rready2),
        .m_axi_awvalid(awvalid2), .m_axi_wvalid(wvalid2), .m_axi_bready(bready2),
        .m_axi_awaddr(awaddr2), .m_axi_wdata(wdata2), .m_axi_wstrb(wstrb2));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave model for the main DUT, updated on the falling edge.
    logic        slv_en = 1'b1;
    int          ar_wait = 0, r_wait = 0, ar_cnt = 0, r_cnt = 0;
    logic        bad_en = 1'b0, hold_en = 1'b0;
    logic [31:0] bad_addr = 32'd0, hold_addr = 32'd0, lat = 32'd0, ar_prev = 32'd0;
    logic        ar_seen = 1'b0, force_rv = 1'b0;
    logic [31:0] force_rd = 32'd0;
    int          stab_err = 0, overlap = 0;

    initial begin
        arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'b00;
    end

    always @(negedge clk) begin
        if (arvalid && rready) overlap++;
        if (!slv_en) begin
            arready = 1'b0; rvalid = force_rv; rdata = force_rd; rresp = 2'b00;
            ar_cnt = 0; r_cnt = 0; ar_seen = 1'b0;
        end else begin
            if (arvalid) begin
                if (ar_seen && araddr != ar_prev) stab_err++;
                ar_seen = 1'b1; ar_prev = araddr;
                if (ar_cnt == ar_wait) begin
                    arready = 1'b1; lat = araddr; ar_cnt = 0;
                end else begin
                    arready = 1'b0; ar_cnt++;
                end
            end else begin
                arready = 1'b0; ar_cnt = 0; ar_seen = 1'b0;
            end
            if (rready && !(hold_en && lat == hold_addr)) begin
                if (r_cnt == r_wait) begin
                    rvalid = 1'b1; rdata = 32'hC000_0000 | lat;
                    rresp  = (bad_en && lat == bad_addr) ? 2'b10 : 2'b00;
                    r_cnt  = 0;
                end else begin
                    rvalid = 1'b0; r_cnt++;
                end
            end else begin
                rvalid = 1'b0; r_cnt = 0;
            end
        end
    end

    // Zero-wait slave for the second DUT
    logic [31:0] lat2 = 32'd0;
    initial begin
        arready2 = 1'b0; rvalid2 = 1'b0; rdata2 = 32'd0; rresp2 = 2'b00;
    end
    always @(negedge clk) begin
        arready2 = arvalid2;
        if (arvalid2) lat2 = araddr2;
        rvalid2 = rready2;
        rdata2  = 32'hC000_0000 | lat2;
    end

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    // Called on the negedge of cycle 1; returns the cycle on which done was seen.
    task automatic wait_done(input string name, input int limit, output int cyc);
        cyc = 1;
        while (!done && cyc < limit) begin
            @(negedge clk); cyc++;
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL %s: done not seen within %0d cycles", name, limit);
        end
    endtask

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] exp;
    } rd_vec_t;

    initial begin
        rd_vec_t vecs[6];
        int cyc, dones;
        logic [31:0] acc;

        vecs[0] = '{5'd0,  32'hC000_0000};
        vecs[1] = '{5'd1,  32'hC000_0004};
        vecs[2] = '{5'd5,  32'hC000_0014};
        vecs[3] = '{5'd16, 32'hC000_0040};
        vecs[4] = '{5'd30, 32'hC000_0078};
        vecs[5] = '{5'd31, 32'hC000_007C};

        rst = 1'b1; start = 1'b0; rd_idx = 5'd0; start2 = 1'b0; rd_idx2 = 5'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
        chk("rst_rready", {31'd0, rready}, 32'd0);
        chk("rst_bready", {31'd0, bready}, 32'd1);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_tieoffs", {awvalid, wvalid, awaddr, wdata, wstrb}, 32'd0);
        rd_idx = 5'd5; #1;
        chk("rst_rd_data", rd_data, 32'd0);

        // Test 1: zero-wait snapshot, done 65 cycles after start is sampled
        pulse_start();
        chk("t1_busy_after_start", {31'd0, busy}, 32'd1);
        wait_done("t1_done", 200, cyc);
        chk("t1_latency", cyc, 32'd65);
        chk("t1_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        chk("t1_done_one_cycle", {31'd0, done}, 32'd0);
        chk("t1_busy_idle", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            rd_idx = vecs[i].idx; #1;
            chk($sformatf("t1_rd[%0d]", vecs[i].idx), rd_data, vecs[i].exp);
        end

        // Short buffer at the top of the address space
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        cyc = 1;
        while (!done2 && cyc < 50) begin @(negedge clk); cyc++; end
        chk("w_latency", cyc, 32'd9);
        rd_idx2 = 5'd0; #1; chk("w_rd0", rd_data2, 32'hFFFF_FFF8);
        rd_idx2 = 5'd1; #1; chk("w_rd1", rd_data2, 32'hFFFF_FFFC);
        rd_idx2 = 5'd2; #1; chk("w_rd2_wrap", rd_data2, 32'hC000_0000);
        rd_idx2 = 5'd3; #1; chk("w_rd3", rd_data2, 32'hC000_0004);
        rd_idx2 = 5'd4; #1; chk("w_rd4_oob", rd_data2, 32'd0);
        rd_idx2 = 5'd31; #1; chk("w_rd31_oob", rd_data2, 32'd0);

        // Test 2: slave wait states
        ar_wait = 3; r_wait = 4; stab_err = 0;
        pulse_start();
        wait_done("t2_done", 2000, cyc);
        chk("t2_latency", cyc, 32'd289);
        chk("t2_araddr_stable", stab_err, 32'd0);
        rd_idx = 5'd9;  #1; chk("t2_rd9", rd_data, 32'hC000_0024);
        rd_idx = 5'd31; #1; chk("t2_rd31", rd_data, 32'hC000_007C);
        ar_wait = 0; r_wait = 0;

        // Test 3: SLVERR on word 7
        bad_en = 1'b1; bad_addr = 32'd28;
        pulse_start();
        wait_done("t3_done", 200, cyc);
        chk("t3_err_set", {31'd0, err}, 32'd1);
        rd_idx = 5'd7; #1; chk("t3_rd7", rd_data, 32'hC000_001C);
        bad_en = 1'b0;
        @(negedge clk);
        chk("t3_err_sticky", {31'd0, err}, 32'd1);
        pulse_start();
        chk("t3_err_cleared", {31'd0, err}, 32'd0);
        wait_done("t3b_done", 200, cyc);
        chk("t3b_err", {31'd0, err}, 32'd0);

        // Test 4: starts while busy and in the DONE cycle are dropped
        @(negedge clk); start = 1'b1; dones = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (done) dones++;
            start = (n == 2 || n == 10 || done);
        end
        start = 1'b0;
        chk("t4_done_count", dones, 32'd1);
        chk("t4_idle_after", {31'd0, busy}, 32'd0);

        // Test 5: reset while waiting for word 9's data
        r_wait = 4;
        pulse_start();
        cyc = 0;
        while (!(rready && araddr == 32'd36) && cyc < 200) begin @(negedge clk); cyc++; end
        chk("t5_reached_r9", {31'd0, rready && araddr == 32'd36}, 32'd1);
        rst = 1'b1; slv_en = 1'b0;
        @(negedge clk);
        rst = 1'b0; force_rv = 1'b1; force_rd = 32'h1234_5678;
        chk("t5_arvalid", {31'd0, arvalid}, 32'd0);
        chk("t5_rready", {31'd0, rready}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        force_rv = 1'b0;
        acc = 32'd0;
        for (int i = 0; i < 32; i++) begin
            rd_idx = 5'(i); #1; acc = acc | rd_data;
        end
        chk("t5_buffer_zero", acc, 32'd0);
        chk("t5_still_idle", {31'd0, busy}, 32'd0);
        chk("t5_no_done", {31'd0, done}, 32'd0);
        slv_en = 1'b1; r_wait = 0;

`ifdef PERF_READER_TIMEOUT_EN
        // Test 6: word 3 never answered, watchdog ends the snapshot
        hold_en = 1'b1; hold_addr = 32'd12;
        pulse_start();
        cyc = 0;
        while (!(rready && araddr == 32'd12) && cyc < 200) begin @(negedge clk); cyc++; end
        cyc = 0;
        while (!done && cyc < 100) begin @(negedge clk); cyc++; end
        chk("t6_timeout_latency", cyc, 32'd16);
        chk("t6_err", {31'd0, err}, 32'd1);
        rd_idx = 5'd3; #1; chk("t6_rd3", rd_data, 32'hDEAD_BEEF);
        rd_idx = 5'd2; #1; chk("t6_rd2", rd_data, 32'hC000_0008);
        rd_idx = 5'd4; #1; chk("t6_rd4_old", rd_data, 32'd0);
        hold_en = 1'b0;
`endif

        chk("never_arvalid_and_rready", overlap, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
